// File: rtl/entry_pkg.sv
// Shared encodings for the key entry front end: FSM states, key indices, default width.
package entry_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_AMOUNT = 2'd0,
        ST_WAIT_KEY    = 2'd1,
        ST_PRESENT     = 2'd2,
        ST_UNUSED      = 2'd3
    } entry_state_e;

    localparam int KEY_START  = 0;
    localparam int KEY_LOAD   = 1;
    localparam int KEY_CANCEL = 2;

    localparam int ENTRY_DATA_W = 8;

endpackage

// File: rtl/debounce_cell.sv
// One pushbutton: 2-FF synchroniser, debounce counter, stable level and press pulse.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync_a;
    logic             sync_b;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a      <= 1'b1;
            sync_b      <= 1'b1;
            stable      <= 1'b1;
            stable_d    <= 1'b1;
            count       <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync_a      <= key_n;
            sync_b      <= sync_a;
            stable_d    <= stable;
            press_pulse <= stable_d & ~stable;
            // A new level is accepted only after it has differed from stable for a full window.
            if (sync_b == stable) begin
                count <= '0;
            end else if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync_b;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_entry_frontend.sv
// Debounced key front end with amount/key entry FSM and valid/ready output.
// Optional build macro ENTRY_CANCEL_EN enables the cancel key on key_n[2].
module key_entry_frontend
    import entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DATA_W          = ENTRY_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        key_n,
    input  logic [DATA_W-1:0] sw,
    output logic              start_pulse,
    output logic              load_pulse,
    output logic [DATA_W-1:0] amount_out,
    output logic [DATA_W-1:0] key_out,
    output logic              entry_valid,
    input  logic              entry_ready,
    output logic [1:0]        entry_state
);

    entry_state_e state;
    entry_state_e state_next;
    logic         cap_amount;
    logic         cap_key;

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clock      (clock),
        .reset      (reset),
        .key_n      (key_n[KEY_START]),
        .press_pulse(start_pulse)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clock      (clock),
        .reset      (reset),
        .key_n      (key_n[KEY_LOAD]),
        .press_pulse(load_pulse)
    );

`ifdef ENTRY_CANCEL_EN
    logic cancel_pulse;

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
        .clock      (clock),
        .reset      (reset),
        .key_n      (key_n[KEY_CANCEL]),
        .press_pulse(cancel_pulse)
    );
`else
    logic unused_cancel;
    assign unused_cancel = key_n[KEY_CANCEL];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_WAIT_AMOUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cap_amount = 1'b0;
        cap_key    = 1'b0;
        case (state)
            ST_WAIT_AMOUNT: begin
                if (load_pulse) begin
                    cap_amount = 1'b1;
                    state_next = ST_WAIT_KEY;
                end
            end
            ST_WAIT_KEY: begin
                if (load_pulse) begin
                    cap_key    = 1'b1;
                    state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (entry_ready) begin
                    state_next = ST_WAIT_AMOUNT;
                end
            end
            default: state_next = ST_WAIT_AMOUNT;
        endcase
`ifdef ENTRY_CANCEL_EN
        // Cancel overrides both a pending capture and the handshake.
        if (cancel_pulse) begin
            state_next = ST_WAIT_AMOUNT;
            cap_amount = 1'b0;
            cap_key    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            amount_out <= '0;
            key_out    <= '0;
        end else begin
            if (cap_amount) amount_out <= sw;
            if (cap_key)    key_out    <= sw;
        end
    end

    assign entry_valid = (state == ST_PRESENT);
    assign entry_state = state;

endmodule

// File: tb/tb_key_entry_frontend.sv
// Self-checking bench for key_entry_frontend with a sample-history reference model.
module tb_key_entry_frontend;

    localparam int DB = 4;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    key_n = 3'b111;
    logic [DW-1:0] sw = '0;
    logic          entry_ready = 1'b0;
    logic          start_pulse;
    logic          load_pulse;
    logic [DW-1:0] amount_out;
    logic [DW-1:0] key_out;
    logic          entry_valid;
    logic [1:0]    entry_state;

    key_entry_frontend #(.DEBOUNCE_CYCLES(DB), .DATA_W(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .key_n      (key_n),
        .sw         (sw),
        .start_pulse(start_pulse),
        .load_pulse (load_pulse),
        .amount_out (amount_out),
        .key_out    (key_out),
        .entry_valid(entry_valid),
        .entry_ready(entry_ready),
        .entry_state(entry_state)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    int lp_cnt   = 0;
    int sp_cnt   = 0;
    bit chk_en   = 1'b0;

    // Reference model: raw sample history per key, stable level history, FSM as plain values.
    logic          hist [3][0:DB+1];
    logic          s1 [3];
    logic          s2 [3];
    logic          mp [3];
    logic          np;
    logic          flip;
    int            m_state;
    logic [DW-1:0] m_amount;
    logic [DW-1:0] m_key;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j <= DB + 1; j++) hist[i][j] = 1'b1;
                s1[i] = 1'b1;
                s2[i] = 1'b1;
                mp[i] = 1'b0;
            end
            m_state  = 0;
            m_amount = '0;
            m_key    = '0;
        end else begin
`ifdef ENTRY_CANCEL_EN
            if (mp[2]) m_state = 0;
            else
`endif
            if (m_state == 2) begin
                if (entry_ready) m_state = 0;
            end else if (m_state == 1) begin
                if (mp[1]) begin m_key = sw; m_state = 2; end
            end else begin
                if (mp[1]) begin m_amount = sw; m_state = 1; end
            end
            for (int i = 0; i < 3; i++) begin
                np = s2[i] & ~s1[i];
                for (int j = DB + 1; j > 0; j--) hist[i][j] = hist[i][j-1];
                hist[i][0] = key_n[i];
                flip = 1'b1;
                for (int j = 2; j <= DB + 1; j++) if (hist[i][j] == s1[i]) flip = 1'b0;
                s2[i] = s1[i];
                if (flip) s1[i] = ~s1[i];
                mp[i] = np;
            end
        end
    end

    always @(negedge clock) begin
        if (load_pulse === 1'b1) lp_cnt++;
        if (start_pulse === 1'b1) sp_cnt++;
        if (chk_en) begin
            n_assert++;
            if ({start_pulse, load_pulse, amount_out, key_out, entry_valid, entry_state} !==
                {mp[0], mp[1], m_amount, m_key, (m_state == 2), 2'(m_state)}) begin
                n_fail++;
                $display("FAIL cycle_cmp @%0t: got sp=%b lp=%b amt=%h key=%h vld=%b st=%0d, expected sp=%b lp=%b amt=%h key=%h vld=%b st=%0d",
                         $time, start_pulse, load_pulse, amount_out, key_out, entry_valid, entry_state,
                         mp[0], mp[1], m_amount, m_key, (m_state == 2), m_state);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input int idx, input int hold);
        key_n[idx] = 1'b0;
        tick(hold);
        key_n[idx] = 1'b1;
        tick(12);
    endtask

    int hits;
    int first;

    initial begin
        tick(1);
        chk_en = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        check("reset_state", 32'(entry_state), 0);
        check("reset_valid", 32'(entry_valid), 0);
        check("reset_data", {16'h0, amount_out, key_out}, 0);
        check("reset_pulses", {30'h0, start_pulse, load_pulse}, 0);

        // Short glitch on load must be swallowed.
        lp_cnt = 0;
        key_n[1] = 1'b0;
        tick(3);
        key_n[1] = 1'b1;
        tick(12);
        check("glitch_no_pulse", 32'(lp_cnt), 0);
        check("glitch_state", 32'(entry_state), 0);

        // Start latency: driven low just after edge 0, pulse expected after edge 7 only.
        key_n[0] = 1'b0;
        hits = 0;
        first = 0;
        for (int j = 1; j <= 10; j++) begin
            tick(1);
            if (start_pulse) begin
                hits++;
                if (first == 0) first = j;
            end
        end
        check("latency_count", 32'(hits), 1);
        check("latency_edge", 32'(first), 7);
        tick(5);
        key_n[0] = 1'b1;
        sp_cnt = 0;
        tick(15);
        check("release_no_pulse", 32'(sp_cnt), 0);

        // Two-step entry.
        sw = 8'h2A;
        press(1, 6);
        sw = 8'h05;
        press(1, 6);
        check("entry_amount", 32'(amount_out), 32'h2A);
        check("entry_key", 32'(key_out), 32'h05);
        check("entry_valid", 32'(entry_valid), 1);
        check("entry_state", 32'(entry_state), 2);

        // Backpressure with an ignored load press.
        tick(20);
        sw = 8'hFF;
        press(1, 6);
        check("bp_valid", 32'(entry_valid), 1);
        check("bp_data", {16'h0, amount_out, key_out}, 32'h2A05);
        check("bp_state", 32'(entry_state), 2);
        entry_ready = 1'b1;
        tick(1);
        entry_ready = 1'b0;
        check("xfer_valid", 32'(entry_valid), 0);
        check("xfer_state", 32'(entry_state), 0);

        // Reset while waiting for the key.
        sw = 8'h11;
        press(1, 6);
        check("mid_state", 32'(entry_state), 1);
        check("mid_amount", 32'(amount_out), 32'h11);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check("rst_mid_state", 32'(entry_state), 0);
        check("rst_mid_data", {16'h0, amount_out, key_out}, 0);
        check("rst_mid_valid", 32'(entry_valid), 0);
        lp_cnt = 0;
        sp_cnt = 0;
        tick(20);
        check("rst_mid_no_pulses", 32'(lp_cnt + sp_cnt), 0);

        // Cancel key behaviour.
        sw = 8'h33;
        press(1, 6);
        sw = 8'h44;
        press(1, 6);
        check("cancel_pre_state", 32'(entry_state), 2);
`ifdef ENTRY_CANCEL_EN
        key_n[2] = 1'b0;
        tick(7);
        entry_ready = 1'b1;
        tick(1);
        check("cancel_state", 32'(entry_state), 0);
        check("cancel_valid", 32'(entry_valid), 0);
        tick(5);
        check("cancel_no_ready_resp", 32'(entry_state), 0);
        check("cancel_data_kept", {16'h0, amount_out, key_out}, 32'h3344);
        entry_ready = 1'b0;
        key_n[2] = 1'b1;
        tick(12);
`else
        press(2, 6);
        check("nocancel_state", 32'(entry_state), 2);
        check("nocancel_valid", 32'(entry_valid), 1);
        entry_ready = 1'b1;
        tick(1);
        entry_ready = 1'b0;
        check("nocancel_xfer", 32'(entry_state), 0);
`endif

        // Randomised traffic, checked every cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 5) == 0) key_n[i] = ~key_n[i];
            end
            sw          = DW'($urandom);
            entry_ready = ($urandom_range(0, 3) == 0);
            reset       = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
